// File: rtl/conv2d_layer_read_scheduler.sv
// Frame sequencer for a multi-channel conv2D stage: lock-stepped FIFO reads, output pixel tracking.
// Optional macro CONV_SEQ_PERF_EN adds the stall_cycles performance counter.
module conv2d_layer_read_scheduler #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 112,
    parameter int HEIGHT = 112
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_CH-1:0]           fifo_empty,
    input  logic                        ds_ready,
    input  logic                        fm_valid,
    output logic                        rdreq,
    output logic                        conv_valid,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(HEIGHT)-1:0]   out_row,
    output logic [$clog2(WIDTH)-1:0]    out_col,
`ifdef CONV_SEQ_PERF_EN
    output logic [31:0]                 stall_cycles,
`endif
    output logic                        err_overrun
);

    localparam int ICW = $clog2(WIDTH + 2);
    localparam int IRW = $clog2(HEIGHT + 2);
    localparam int OCW = $clog2(WIDTH);
    localparam int ORW = $clog2(HEIGHT);

    localparam logic [ICW-1:0] IN_COL_LAST  = ICW'(WIDTH + 1);
    localparam logic [IRW-1:0] IN_ROW_LAST  = IRW'(HEIGHT + 1);
    localparam logic [OCW-1:0] OUT_COL_LAST = OCW'(WIDTH - 1);
    localparam logic [ORW-1:0] OUT_ROW_LAST = ORW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [ICW-1:0]   in_col_r;
    logic [IRW-1:0]   in_row_r;
    logic [OCW-1:0]   out_col_r;
    logic [ORW-1:0]   out_row_r;
    logic             out_done_r;
    logic             busy_r;
    logic             frame_done_r;
    logic             err_overrun_r;

    logic             rdreq_s;
    logic             last_read_s;
    logic             out_count_en_s;
    logic             overrun_s;

    // Read gating and output-pixel acceptance decode.
    always_comb begin
        rdreq_s        = 1'b0;
        last_read_s    = 1'b0;
        out_count_en_s = 1'b0;
        overrun_s      = 1'b0;
        if (state_r == ST_FILL) begin
            rdreq_s = ~|fifo_empty & ds_ready;
        end else begin
            rdreq_s = 1'b0;
        end
        last_read_s = rdreq_s && (in_col_r == IN_COL_LAST) && (in_row_r == IN_ROW_LAST);
        if ((state_r == ST_FILL || state_r == ST_DRAIN) && !out_done_r) begin
            out_count_en_s = fm_valid;
        end else begin
            overrun_s = fm_valid;
        end
    end

    assign rdreq       = rdreq_s;
    assign conv_valid  = rdreq_s;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign out_row     = out_row_r;
    assign out_col     = out_col_r;
    assign err_overrun = err_overrun_r;

    // Frame FSM with input/output position counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            in_col_r      <= '0;
            in_row_r      <= '0;
            out_col_r     <= '0;
            out_row_r     <= '0;
            out_done_r    <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (overrun_s) begin
                err_overrun_r <= 1'b1;
            end

            // The last pixel wraps both counters back to the origin.
            if (out_count_en_s) begin
                if (out_col_r == OUT_COL_LAST) begin
                    out_col_r <= '0;
                    if (out_row_r == OUT_ROW_LAST) begin
                        out_row_r  <= '0;
                        out_done_r <= 1'b1;
                    end else begin
                        out_row_r <= out_row_r + 1'b1;
                    end
                end else begin
                    out_col_r <= out_col_r + 1'b1;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r       <= ST_FILL;
                        busy_r        <= 1'b1;
                        in_col_r      <= '0;
                        in_row_r      <= '0;
                        out_col_r     <= '0;
                        out_row_r     <= '0;
                        out_done_r    <= 1'b0;
                        err_overrun_r <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (rdreq_s) begin
                        if (in_col_r == IN_COL_LAST) begin
                            in_col_r <= '0;
                            in_row_r <= in_row_r + 1'b1;
                        end else begin
                            in_col_r <= in_col_r + 1'b1;
                        end
                    end
                    if (last_read_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_done_r) begin
                        state_r      <= ST_DONE;
                        frame_done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] stall_cycles_r;

    // Saturating count of FILL cycles where the read was held off.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'd0;
        end else if (state_r == ST_IDLE && start) begin
            stall_cycles_r <= 32'd0;
        end else if (state_r == ST_FILL && !rdreq_s && stall_cycles_r != 32'hFFFF_FFFF) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_conv2d_layer_read_scheduler.sv
// Directed self-checking bench for conv2d_layer_read_scheduler at WIDTH=4, HEIGHT=3 (30 reads, 12 pixels).
module tb_conv2d_layer_read_scheduler;

    localparam int NUM_CH = 8;
    localparam int WIDTH  = 4;
    localparam int HEIGHT = 3;
    localparam int N_READS = (WIDTH + 2) * (HEIGHT + 2);
    localparam int N_PIX   = WIDTH * HEIGHT;

    logic              clk;
    logic              rst;
    logic              start;
    logic [NUM_CH-1:0] fifo_empty;
    logic              ds_ready;
    logic              fm_valid;
    logic              rdreq;
    logic              conv_valid;
    logic              busy;
    logic              frame_done;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              err_overrun;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0]       stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    conv2d_layer_read_scheduler #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fifo_empty   (fifo_empty),
        .ds_ready     (ds_ready),
        .fm_valid     (fm_valid),
        .rdreq        (rdreq),
        .conv_valid   (conv_valid),
        .busy         (busy),
        .frame_done   (frame_done),
        .out_row      (out_row),
        .out_col      (out_col),
`ifdef CONV_SEQ_PERF_EN
        .stall_cycles (stall_cycles),
`endif
        .err_overrun  (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0: clean; mode 1: fifo_empty[5] high for cycles 3..7; mode 2: ds_ready toggles.
    task automatic run_frame(input int mode, input int fm_after, input int start_c, input int abort_c);
        int n_reads;
        int fm_sent;
        int both_c;
        int stall_m;
        int pos;
        bit finished;
        logic [NUM_CH-1:0] emp;
        logic dsr;
        logic fmv;
        logic exp_rd;
        n_reads  = 0;
        fm_sent  = 0;
        both_c   = -1;
        stall_m  = 0;
        finished = 1'b0;
        fifo_empty = '0;
        ds_ready   = 1'b1;
        fm_valid   = 1'b0;
        start      = 1'b1;
        #1;
        check_eq("idle_rdreq", rdreq, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            emp = '0;
            if (mode == 1 && c >= 3 && c <= 7) emp[5] = 1'b1;
            dsr = (mode == 2) ? ((c % 2) == 0) : 1'b1;
            fmv = (n_reads >= fm_after) && (fm_sent < N_PIX);
            if (c == abort_c) begin
                dsr = 1'b0;
                fmv = 1'b0;
                rst = 1'b1;
            end
            fifo_empty = emp;
            ds_ready   = dsr;
            fm_valid   = fmv;
            start      = (c == start_c);
            if (both_c < 0 && n_reads == N_READS && fm_sent == N_PIX) both_c = c;
            #1;
            exp_rd = (n_reads < N_READS) && (emp == '0) && dsr;
            pos = fm_sent % N_PIX;
            check_eq("rdreq", rdreq, exp_rd);
            check_eq("conv_valid", conv_valid, exp_rd);
            check_eq("out_row", out_row, pos / WIDTH);
            check_eq("out_col", out_col, pos % WIDTH);
            check_eq("busy", busy, (both_c < 0) || (c <= both_c + 1));
            check_eq("frame_done", frame_done, (both_c >= 0) && (c == both_c + 1));
            check_eq("err_overrun", err_overrun, 1'b0);
            if (both_c >= 0 && c == both_c + 2) begin
                finished = 1'b1;
                break;
            end
            if (n_reads < N_READS && !exp_rd) stall_m++;
            if (exp_rd) n_reads++;
            if (fmv) fm_sent++;
            if (c == abort_c) begin
                @(posedge clk); #1;
                rst        = 1'b0;
                start      = 1'b0;
                fifo_empty = '0;
                ds_ready   = 1'b1;
                #1;
                check_eq("abort_rdreq", rdreq, 1'b0);
                check_eq("abort_busy", busy, 1'b0);
                check_eq("abort_done", frame_done, 1'b0);
                check_eq("abort_row", out_row, 2'd0);
                check_eq("abort_col", out_col, 2'd0);
                check_eq("abort_err", err_overrun, 1'b0);
                return;
            end
            @(posedge clk); #1;
        end
        check_eq("frame_finished", finished, 1'b1);
        check_eq("read_total", n_reads, N_READS);
`ifdef CONV_SEQ_PERF_EN
        check_eq("stall_cycles", stall_cycles, stall_m);
`endif
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        fifo_empty = '1;
        ds_ready   = 1'b0;
        fm_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_rdreq", rdreq, 1'b0);
        check_eq("rst_conv_valid", conv_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_out_row", out_row, 2'd0);
        check_eq("rst_out_col", out_col, 2'd0);
        check_eq("rst_err", err_overrun, 1'b0);
        @(posedge clk); #1;

        run_frame(0, 14, -1, -1);
        run_frame(1, 14, -1, -1);
        run_frame(2, 14, -1, -1);
        run_frame(0, 18, -1, -1);
        run_frame(0, 25, -1, -1);

        // Stray pixel while idle: sticky error, counters hold.
        fm_valid = 1'b1;
        @(posedge clk); #1;
        fm_valid = 1'b0;
        #1;
        check_eq("ovr_err", err_overrun, 1'b1);
        check_eq("ovr_row", out_row, 2'd0);
        check_eq("ovr_col", out_col, 2'd0);
        check_eq("ovr_busy", busy, 1'b0);
        @(posedge clk); #1;
        check_eq("ovr_err_hold", err_overrun, 1'b1);
        run_frame(0, 14, -1, -1);

        run_frame(0, 5, -1, 10);
        run_frame(0, 14, 5, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
